// File: rtl/ft_fifo_responder_if.sv
// rtl/ft_fifo_responder_if.sv - host-side FIFO handshake interface of the FT FIFO responder
interface ft_fifo_responder_if;
  logic        host_wr_en;
  logic [17:0] host_wr_data;
  logic        host_full;
  logic        host_rd_en;
  logic [17:0] host_rd_data;
  logic        host_empty;

  modport master (
    output host_wr_en, host_wr_data, host_rd_en,
    input  host_full, host_rd_data, host_empty
  );

  modport slave (
    input  host_wr_en, host_wr_data, host_rd_en,
    output host_full, host_rd_data, host_empty
  );
endinterface

// File: rtl/ft_fifo_responder.sv
// rtl/ft_fifo_responder.sv - FT245-style bus responder with rx/tx FIFOs and sticky error flags
module ft_fifo_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic                 TXE_N,
  output logic                 RXF_N,
  input  logic                 OE_N,
  input  logic                 RD_N,
  input  logic                 WR_N,
  inout  wire  [15:0]          DATA,
  inout  wire  [1:0]           BE,
  ft_fifo_responder_if.slave   host,
  output logic [AW:0]          rx_count,
  output logic [AW:0]          tx_count,
  input  logic                 err_clear,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_protocol
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_OE_ARMED = 2'd1;
  localparam logic [1:0] S_READ     = 2'd2;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // rx FIFO: host -> bus master; tx FIFO: bus master -> host
  logic [17:0]   rx_mem [DEPTH];
  logic [17:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [1:0]    rd_state, rd_state_nx;

  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          bus_rd, bus_wr;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic          set_ov, set_un, set_pr;
  logic [AW:0]   rx_count_nx, tx_count_nx;
  logic [17:0]   rx_head, tx_head;

  // Transfer qualification; a bus read is honoured on the edge the FSM moves into
  // READ as well as while it stays there, so one word moves per RD_N-low edge.
  always_comb begin
    rx_empty = (rx_count == '0);
    rx_full  = (rx_count == FULL);
    tx_empty = (tx_count == '0);
    tx_full  = (tx_count == FULL);

    bus_rd   = !OE_N && !RD_N && ((rd_state == S_OE_ARMED) || (rd_state == S_READ));
    rx_pop   = bus_rd && !rx_empty;
    bus_wr   = !WR_N && OE_N;
    tx_pop   = host.host_rd_en && !tx_empty;
    tx_push  = bus_wr && (!tx_full || tx_pop);
    rx_push  = host.host_wr_en && (!rx_full || rx_pop);

    set_ov   = (bus_wr && !tx_push) || (host.host_wr_en && !rx_push);
    set_un   = (bus_rd && rx_empty) || (host.host_rd_en && tx_empty);
    set_pr   = (!RD_N && (rd_state == S_IDLE)) || (!WR_N && !OE_N);

    rx_count_nx = rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    tx_count_nx = tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
  end

  // Read FSM: OE_N must be seen low with RD_N high before reads are accepted
  always_comb begin
    rd_state_nx = rd_state;
    if (OE_N) begin
      rd_state_nx = S_IDLE;
    end else begin
      case (rd_state)
        S_IDLE:     if (RD_N)  rd_state_nx = S_OE_ARMED;
        S_OE_ARMED: if (!RD_N) rd_state_nx = S_READ;
        S_READ:     rd_state_nx = S_READ;
        default:    rd_state_nx = S_IDLE;
      endcase
    end
  end

  // Pointers, counts, FSM, registered bus flags and sticky errors
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      tx_wr_ptr     <= '0;
      tx_rd_ptr     <= '0;
      rx_count      <= '0;
      tx_count      <= '0;
      rd_state      <= S_IDLE;
      RXF_N         <= 1'b1;
      TXE_N         <= 1'b1;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_protocol  <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      rx_count      <= rx_count_nx;
      tx_count      <= tx_count_nx;
      rd_state      <= rd_state_nx;
      RXF_N         <= (rx_count_nx == '0);
      TXE_N         <= (tx_count_nx == FULL);
      err_overflow  <= set_ov || (err_overflow  && !err_clear);
      err_underflow <= set_un || (err_underflow && !err_clear);
      err_protocol  <= set_pr || (err_protocol  && !err_clear);
    end
  end

  // FIFO storage writes; contents are don't-care once pointers are reset
  always_ff @(posedge CLK) begin
    if (!RST && rx_push) rx_mem[rx_wr_ptr] <= host.host_wr_data;
    if (!RST && tx_push) tx_mem[tx_wr_ptr] <= {BE, DATA};
  end

  // FIFO heads, forced to zero when empty so stale storage never leaks out
  always_comb begin
    rx_head = rx_empty ? 18'h0 : rx_mem[rx_rd_ptr];
    tx_head = tx_empty ? 18'h0 : tx_mem[tx_rd_ptr];
  end

  assign DATA = OE_N ? 16'hzzzz : rx_head[15:0];
  assign BE   = OE_N ? 2'bzz    : rx_head[17:16];

  assign host.host_full    = rx_full;
  assign host.host_empty   = tx_empty;
  assign host.host_rd_data = tx_head;

endmodule

// File: tb/tb_ft_fifo_responder.sv
// tb/tb_ft_fifo_responder.sv - scoreboard bench for ft_fifo_responder
module tb_ft_fifo_responder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST, OE_N, RD_N, WR_N, err_clear;
  logic          TXE_N, RXF_N;
  logic [AW:0]   rx_count, tx_count;
  logic          err_overflow, err_underflow, err_protocol;
  logic          tb_drv;
  logic [17:0]   tb_word;
  wire  [15:0]   DATA;
  wire  [1:0]    BE;

  ft_fifo_responder_if hif ();

  assign DATA = tb_drv ? tb_word[15:0]  : 16'hzzzz;
  assign BE   = tb_drv ? tb_word[17:16] : 2'bzz;

  ft_fifo_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .TXE_N(TXE_N), .RXF_N(RXF_N),
    .OE_N(OE_N), .RD_N(RD_N), .WR_N(WR_N), .DATA(DATA), .BE(BE),
    .host(hif.slave), .rx_count(rx_count), .tx_count(tx_count),
    .err_clear(err_clear), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_protocol(err_protocol)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW:0] rxc, txc;
    logic        rxf_n, txe_n, h_empty, h_full, eo, eu, ep;
    logic        chk_hrd;
    logic [17:0] hrd;
    logic        chk_bus;
    logic [17:0] bus;
  } snap_t;

  snap_t       sb[$];
  logic [17:0] m_rx[$];
  logic [17:0] m_tx[$];
  bit          m_armed;
  bit          m_eo, m_eu, m_ep;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the next edge
  task automatic step(input bit rst, input bit oe_n, input bit rd_n, input bit wr_n,
                      input logic [17:0] bw, input bit hwe, input logic [17:0] hwd,
                      input bit hre, input bit ec);
    snap_t s;
    bit rd_go, rx_pop, wr_req, tx_pop, tx_push, rx_push, so, su, sp;
    @(negedge CLK);
    RST = rst; OE_N = oe_n; RD_N = rd_n; WR_N = wr_n; err_clear = ec;
    tb_drv = oe_n; tb_word = bw;
    hif.host_wr_en = hwe; hif.host_wr_data = hwd; hif.host_rd_en = hre;
    if (rst) begin
      m_rx.delete(); m_tx.delete();
      m_armed = 0; m_eo = 0; m_eu = 0; m_ep = 0;
    end else begin
      rd_go   = m_armed && !oe_n && !rd_n;
      rx_pop  = rd_go && (m_rx.size() > 0);
      wr_req  = !wr_n && oe_n;
      tx_pop  = hre && (m_tx.size() > 0);
      tx_push = wr_req && ((m_tx.size() < DEPTH) || tx_pop);
      rx_push = hwe && ((m_rx.size() < DEPTH) || rx_pop);
      so = (wr_req && !tx_push) || (hwe && !rx_push);
      su = (rd_go && m_rx.size() == 0) || (hre && m_tx.size() == 0);
      sp = (!rd_n && !m_armed) || (!wr_n && !oe_n);
      if (rx_pop)  void'(m_rx.pop_front());
      if (tx_pop)  void'(m_tx.pop_front());
      if (tx_push) m_tx.push_back(bw);
      if (rx_push) m_rx.push_back(hwd);
      m_armed = !oe_n && (m_armed || rd_n);
      m_eo = so || (m_eo && !ec);
      m_eu = su || (m_eu && !ec);
      m_ep = sp || (m_ep && !ec);
    end
    s.rxc     = (AW+1)'(m_rx.size());
    s.txc     = (AW+1)'(m_tx.size());
    s.rxf_n   = rst ? 1'b1 : (m_rx.size() == 0);
    s.txe_n   = rst ? 1'b1 : (m_tx.size() == DEPTH);
    s.h_empty = (m_tx.size() == 0);
    s.h_full  = (m_rx.size() == DEPTH);
    s.eo = m_eo; s.eu = m_eu; s.ep = m_ep;
    s.chk_hrd = (m_tx.size() > 0);
    s.hrd     = (m_tx.size() > 0) ? m_tx[0] : 18'h0;
    s.chk_bus = !oe_n;
    s.bus     = (m_rx.size() > 0) ? m_rx[0] : 18'h0;
    sb.push_back(s);
  endtask

  task automatic idle();
    step(0, 1, 1, 1, 18'h0, 0, 18'h0, 0, 0);
  endtask

  task automatic host_push(input logic [17:0] w);
    step(0, 1, 1, 1, 18'h0, 1, w, 0, 0);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest expected snapshot
  initial begin
    snap_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rx_count", 32'(rx_count), 32'(e.rxc));
        chk("tx_count", 32'(tx_count), 32'(e.txc));
        chk("RXF_N", 32'(RXF_N), 32'(e.rxf_n));
        chk("TXE_N", 32'(TXE_N), 32'(e.txe_n));
        chk("host_empty", 32'(hif.host_empty), 32'(e.h_empty));
        chk("host_full", 32'(hif.host_full), 32'(e.h_full));
        chk("err_overflow", 32'(err_overflow), 32'(e.eo));
        chk("err_underflow", 32'(err_underflow), 32'(e.eu));
        chk("err_protocol", 32'(err_protocol), 32'(e.ep));
        if (e.chk_hrd) chk("host_rd_data", 32'(hif.host_rd_data), 32'(e.hrd));
        if (e.chk_bus) chk("bus_data", 32'({BE, DATA}), 32'(e.bus));
      end
    end
  end

  initial begin
    int mode;
    bit oe, rd, wr, hwe, hre;
    RST = 1; OE_N = 1; RD_N = 1; WR_N = 1; err_clear = 0; tb_drv = 1; tb_word = '0;
    hif.host_wr_en = 0; hif.host_wr_data = '0; hif.host_rd_en = 0;

    // reset, then first released edge
    step(1, 1, 1, 1, 18'h0, 0, 18'h0, 0, 0);
    step(1, 1, 1, 1, 18'h0, 0, 18'h0, 0, 0);
    idle();

    // host pushes two words, master arms then reads both
    host_push({2'b11, 16'h1234});
    host_push({2'b11, 16'hABCD});
    idle();
    step(0, 0, 1, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    idle();

    // master fills tx FIFO, 17th write overflows, host drains plus one extra
    for (int i = 1; i <= 17; i++) step(0, 1, 1, 0, {2'b11, 16'(i)}, 0, 18'h0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 1, 18'h0, 0, 18'h0, 1, 0);
    step(0, 1, 1, 1, 18'h0, 0, 18'h0, 0, 1);

    // RD_N low on the same edge OE_N falls
    host_push({2'b01, 16'h5555});
    host_push({2'b10, 16'h6666});
    step(0, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 1, 1, 1, 18'h0, 0, 18'h0, 0, 1);

    // rx full, host push and bus pop on the same edge, then drain
    for (int i = 0; i < 14; i++) host_push({2'(i), 16'h7000 + 16'(i)});
    step(0, 0, 1, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 0, 0, 1, 18'h0, 1, {2'b11, 16'hBEEF}, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 1, 1, 1, 18'h0, 0, 18'h0, 0, 1);

    // reset in the middle of a read with words queued
    for (int i = 0; i < 5; i++) host_push({2'b11, 16'h0A00 + 16'(i)});
    step(0, 0, 1, 1, 18'h0, 0, 18'h0, 0, 0);
    step(0, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    step(1, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    step(1, 0, 0, 1, 18'h0, 0, 18'h0, 0, 0);
    idle();
    idle();

    // bus write while OE_N low, then clear
    step(0, 1, 1, 0, {2'b10, 16'hC0DE}, 0, 18'h0, 0, 0);
    step(0, 0, 1, 0, {2'b01, 16'hDEAD}, 0, 18'h0, 0, 0);
    step(0, 1, 1, 1, 18'h0, 0, 18'h0, 0, 1);
    idle();

    // randomized traffic in bursts of read-heavy, write-heavy and chaotic cycles
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 8 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0: begin
          oe = ($urandom_range(0, 7) == 0);
          rd = ($urandom_range(0, 2) == 0);
          wr = ($urandom_range(0, 15) != 0);
          hwe = ($urandom_range(0, 3) != 0);
          hre = ($urandom_range(0, 3) == 0);
        end
        1: begin
          oe = 1'b1;
          rd = ($urandom_range(0, 31) != 0);
          wr = ($urandom_range(0, 3) == 0);
          hwe = ($urandom_range(0, 3) == 0);
          hre = ($urandom_range(0, 2) == 0);
        end
        default: begin
          oe = 1'($urandom_range(0, 1));
          rd = 1'($urandom_range(0, 1));
          wr = 1'($urandom_range(0, 1));
          hwe = 1'($urandom_range(0, 1));
          hre = 1'($urandom_range(0, 1));
        end
      endcase
      step(($urandom_range(0, 299) == 0), oe, rd, wr, 18'($urandom), hwe, 18'($urandom),
           hre, ($urandom_range(0, 15) == 0));
    end

    idle();
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
